// File: rtl/slope_actuator.sv
// slope_actuator: drives the incline lift motor toward the clamped target slope,
// tracks position in sub-steps, honours the limit switches and enforces a settle
// dead time at every stop. Optional build macro HOMING_EN: after reset, seek the
// bottom limit switch before accepting targets.
//
// state  | meaning
// IDLE   | motor off, compare clamped target against current level
// UP     | motor_up on, sub-step ticks raise the level
// DOWN   | motor_down on, sub-step ticks lower the level
// SETTLE | motor off for SETTLE_CYCLES before the next decision
// FAULT  | top limit hit while raising (or homing timed out); held until reset
// HOME   | lowering toward the bottom limit switch to re-zero (HOMING_EN only)
module slope_actuator #(
    parameter int unsigned STEP_CYCLES     = 50000,
    parameter int unsigned STEPS_PER_LEVEL = 4,
    parameter int unsigned MAX_LEVEL       = 10,
    parameter int unsigned SETTLE_CYCLES   = 25000000
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [3:0] target_slope,
    input  logic       limit_low,
    input  logic       limit_high,
    output logic       motor_up,
    output logic       motor_down,
    output logic [3:0] current_slope,
    output logic       busy,
    output logic       at_target,
    output logic       fault
);

    typedef enum logic [2:0] {IDLE, UP, DOWN, SETTLE, FAULT, HOME} state_t;

    localparam int unsigned PW = $clog2(STEP_CYCLES + 1);
    localparam int unsigned SW = $clog2(STEPS_PER_LEVEL + 1);
    localparam int unsigned TW = $clog2(SETTLE_CYCLES + 1);
    localparam logic [3:0]    MAX_L       = 4'(MAX_LEVEL);
    localparam logic [PW-1:0] PRE_LAST    = PW'(STEP_CYCLES - 1);
    localparam logic [SW-1:0] SUB_LAST    = SW'(STEPS_PER_LEVEL - 1);
    localparam logic [TW-1:0] SETTLE_LAST = TW'(SETTLE_CYCLES - 1);

`ifdef HOMING_EN
    localparam state_t      RESET_STATE = HOME;
    localparam int unsigned HOME_TICKS  = (MAX_LEVEL + 1) * STEPS_PER_LEVEL;
    localparam int unsigned HW          = $clog2(HOME_TICKS + 1);
    localparam logic [HW-1:0] HOME_LAST = HW'(HOME_TICKS - 1);
    logic [HW-1:0] home_q, home_d;
`else
    localparam state_t RESET_STATE = IDLE;
`endif

    state_t        state_q, state_d;
    logic [3:0]    cur_q, cur_d;
    logic [SW-1:0] sub_q, sub_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [TW-1:0] settle_q, settle_d;
    logic          motor_up_q, motor_up_d;
    logic          motor_down_q, motor_down_d;
    logic          busy_q, busy_d;
    logic          at_target_q, at_target_d;
    logic          fault_q, fault_d;
    logic [3:0]    tgt;
    logic [3:0]    new_up, new_dn;
    logic          tick;

    // Next-state, position bookkeeping and registered-output decode.
    always_comb begin
        state_d  = state_q;
        cur_d    = cur_q;
        sub_d    = sub_q;
        pre_d    = pre_q;
        settle_d = settle_q;
`ifdef HOMING_EN
        home_d   = home_q;
`endif
        tgt    = (target_slope > MAX_L) ? MAX_L : target_slope;
        tick   = (pre_q == PRE_LAST);
        new_up = cur_q + 4'd1;
        new_dn = cur_q - 4'd1;

        case (state_q)
            IDLE: begin
                if (tgt > cur_q) begin
                    state_d = UP;
                    pre_d   = '0;
                end else if (tgt < cur_q) begin
                    state_d = DOWN;
                    pre_d   = '0;
                end
            end
            UP: begin
                if (limit_high) begin
                    state_d = FAULT;
                end else begin
                    pre_d = tick ? '0 : pre_q + PW'(1);
                    if (tick) begin
                        if (sub_q == SUB_LAST) begin
                            sub_d = '0;
                            cur_d = new_up;
                            // target is only sampled here, at the level boundary
                            if (new_up >= tgt || new_up >= MAX_L) begin
                                state_d  = SETTLE;
                                settle_d = SETTLE_LAST;
                            end
                        end else begin
                            sub_d = sub_q + SW'(1);
                        end
                    end
                end
            end
            DOWN: begin
                if (limit_low) begin
                    // bottom switch re-zeroes the position; not a fault
                    cur_d    = '0;
                    sub_d    = '0;
                    state_d  = SETTLE;
                    settle_d = SETTLE_LAST;
                end else begin
                    pre_d = tick ? '0 : pre_q + PW'(1);
                    if (tick) begin
                        if (sub_q == SUB_LAST) begin
                            sub_d = '0;
                            cur_d = new_dn;
                            if (new_dn <= tgt || new_dn == 4'd0) begin
                                state_d  = SETTLE;
                                settle_d = SETTLE_LAST;
                            end
                        end else begin
                            sub_d = sub_q + SW'(1);
                        end
                    end
                end
            end
            SETTLE: begin
                if (settle_q == '0) begin
                    state_d = IDLE;
                end else begin
                    settle_d = settle_q - TW'(1);
                end
            end
`ifdef HOMING_EN
            HOME: begin
                if (limit_low) begin
                    cur_d    = '0;
                    sub_d    = '0;
                    state_d  = SETTLE;
                    settle_d = SETTLE_LAST;
                end else begin
                    pre_d = tick ? '0 : pre_q + PW'(1);
                    if (tick) begin
                        if (home_q == HOME_LAST) begin
                            state_d = FAULT;
                        end else begin
                            home_d = home_q + HW'(1);
                        end
                    end
                end
            end
`endif
            default: begin
                state_d = state_q;
            end
        endcase

        motor_up_d   = (state_d == UP);
        motor_down_d = (state_d == DOWN) || (state_d == HOME);
        busy_d       = (state_d == UP) || (state_d == DOWN) ||
                       (state_d == SETTLE) || (state_d == HOME);
        at_target_d  = (state_d == IDLE) && (cur_d == tgt);
        fault_d      = (state_d == FAULT);
    end

    // State, counters and output registers with synchronous reset.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q      <= RESET_STATE;
            cur_q        <= '0;
            sub_q        <= '0;
            pre_q        <= '0;
            settle_q     <= '0;
            motor_up_q   <= 1'b0;
            motor_down_q <= 1'b0;
            busy_q       <= 1'b0;
            at_target_q  <= 1'b0;
            fault_q      <= 1'b0;
`ifdef HOMING_EN
            home_q       <= '0;
`endif
        end else begin
            state_q      <= state_d;
            cur_q        <= cur_d;
            sub_q        <= sub_d;
            pre_q        <= pre_d;
            settle_q     <= settle_d;
            motor_up_q   <= motor_up_d;
            motor_down_q <= motor_down_d;
            busy_q       <= busy_d;
            at_target_q  <= at_target_d;
            fault_q      <= fault_d;
`ifdef HOMING_EN
            home_q       <= home_d;
`endif
        end
    end

    assign motor_up      = motor_up_q;
    assign motor_down    = motor_down_q;
    assign current_slope = cur_q;
    assign busy          = busy_q;
    assign at_target     = at_target_q;
    assign fault         = fault_q;

endmodule

// File: tb/tb_slope_actuator.sv
// tb_slope_actuator: random and directed moves against a timing model built from
// level counts (cycles per level, settle length) rather than the FSM structure.
module tb_slope_actuator;
    localparam int STEP   = 4;
    localparam int SPL    = 2;
    localparam int MAXL   = 10;
    localparam int SETTLE = 3;
    localparam int CPL    = STEP * SPL;

    logic       CLOCK_50 = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] target_slope = 4'd0;
    logic       limit_low = 1'b0;
    logic       limit_high = 1'b0;
    logic       motor_up, motor_down, busy, at_target, fault;
    logic [3:0] current_slope;

    int tests_run    = 0;
    int tests_failed = 0;
    int model_level  = 0;

    slope_actuator #(
        .STEP_CYCLES    (STEP),
        .STEPS_PER_LEVEL(SPL),
        .MAX_LEVEL      (MAXL),
        .SETTLE_CYCLES  (SETTLE)
    ) dut (
        .CLOCK_50     (CLOCK_50),
        .reset        (reset),
        .target_slope (target_slope),
        .limit_low    (limit_low),
        .limit_high   (limit_high),
        .motor_up     (motor_up),
        .motor_down   (motor_down),
        .current_slope(current_slope),
        .busy         (busy),
        .at_target    (at_target),
        .fault        (fault)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic check_eq(input string tag, input int obs, input int exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic check_all(input int up, input int dn, input int lvl,
                             input int bsy, input int at, input int flt);
        check_eq("motor_up", int'(motor_up), up);
        check_eq("motor_down", int'(motor_down), dn);
        check_eq("current_slope", int'(current_slope), lvl);
        check_eq("busy", int'(busy), bsy);
        check_eq("at_target", int'(at_target), at);
        check_eq("fault", int'(fault), flt);
    endtask

    // Full move from a settled IDLE: k counts samples after the decision edge.
    task automatic run_move(input int raw);
        int t, n, dir, move_cycles, lvl, moved;
        t = (raw > MAXL) ? MAXL : raw;
        dir = (t > model_level) ? 1 : -1;
        n = (dir > 0) ? t - model_level : model_level - t;
        target_slope = 4'(raw);
        if (n == 0) begin
            step();
            check_all(0, 0, model_level, 0, 1, 0);
            return;
        end
        move_cycles = n * CPL;
        for (int k = 0; k <= move_cycles + SETTLE; k++) begin
            step();
            moved = (k / CPL < n) ? k / CPL : n;
            lvl = model_level + dir * moved;
            check_all(int'(dir > 0 && k < move_cycles), int'(dir < 0 && k < move_cycles),
                      lvl, int'(k < move_cycles + SETTLE),
                      int'(k >= move_cycles + SETTLE), 0);
        end
        model_level = t;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        target_slope = 4'd0;
        limit_low = 1'b0;
        limit_high = 1'b0;
        step();
        step();
        check_all(0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        model_level = 0;
    endtask

    initial begin
        int lvl;
        do_reset();

        run_move(3);
        run_move(12);
        check_eq("clamp_top", int'(current_slope), MAXL);
        run_move(5);
        run_move(2);

        for (int i = 0; i < 10; i++) begin
            run_move(int'($urandom_range(0, 15)));
        end

        // Reversal: moving up from 0 toward 4, target drops to 0 mid level 1.
        do_reset();
        target_slope = 4'd4;
        for (int k = 0; k < 20; k++) begin
            step();
            if (k == 12) target_slope = 4'd0;
            lvl = (k >= 2 * CPL) ? 2 : k / CPL;
            check_all(int'(k < 2 * CPL), 0, lvl, int'(k < 2 * CPL + SETTLE), 0, 0);
        end
        model_level = 2;
        run_move(0);

        // Bottom limit during DOWN re-zeroes without a fault.
        run_move(4);
        target_slope = 4'd1;
        for (int k = 0; k <= 10; k++) begin
            step();
            check_all(0, 1, 4 - k / CPL, 1, 0, 0);
        end
        limit_low = 1'b1;
        step();
        limit_low = 1'b0;
        check_all(0, 0, 0, 1, 0, 0);
        step();
        step();
        check_eq("rezero_settle", int'(busy), 1);
        step();
        check_all(0, 0, 0, 0, 0, 0);
        model_level = 0;
        run_move(1);

        // Top limit during UP latches a fault that only reset clears.
        do_reset();
        target_slope = 4'd8;
        for (int k = 0; k <= 50; k++) begin
            step();
            if (k >= 48) check_eq("up_level6", int'(current_slope), 6);
        end
        limit_high = 1'b1;
        step();
        check_all(0, 0, 6, 0, 0, 1);
        limit_high = 1'b0;
        target_slope = 4'd2;
        for (int k = 0; k < 20; k++) step();
        check_all(0, 0, 6, 0, 0, 1);
        do_reset();
        check_eq("fault_cleared", int'(fault), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
